// File: rtl/pwm_spi_regbank.sv
// Byte-protocol command decoder and PWM configuration register bank behind an SPI slave.
// Optional: define PWM_REGBANK_CHECKSUM_EN to require an XOR checksum byte on write frames.
module pwm_spi_regbank #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int NUM_REGS       = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    output logic [31:0] counter_value,
    output logic [31:0] prescaler,
    output logic [31:0] duty_cycle_1,
    output logic [31:0] duty_cycle_2,
    output logic [31:0] duty_cycle_3,
    output logic        enable_pwm,
    output logic        frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef PWM_REGBANK_CHECKSUM_EN
    localparam int HW = 32;
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHK} state_t;
    logic [7:0] chk_q, chk_d;
`else
    localparam int HW = 24;
    typedef enum logic [1:0] {S_IDLE, S_DATA} state_t;
`endif

    // Handshake: each rx_dv pulse is answered by exactly one tx_dv pulse on the following
    // cycle; tx_byte is valid only while tx_dv is high and is loaded into the SPI shifter.
    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [31:0]   snap_q, snap_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tx_dv_q, tx_dv_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          frame_err_q, frame_err_d;
    logic [31:0]   regs_q [5];
    logic [31:0]   regs_d [5];
    logic          en_q, en_d;

    logic [31:0] wr_data, rd_sel, commit_data;
    logic        cmd_addr_ok, rx_addr_ok, commit_en;

    assign wr_data     = {hold_q[23:0], rx_byte};
    assign cmd_addr_ok = (32'(cmd_q[6:0]) < 32'(NUM_REGS));
    assign rx_addr_ok  = (32'(rx_byte[6:0]) < 32'(NUM_REGS));

    always_comb begin
        rd_sel = 32'h0;
        case (rx_byte[6:0])
            7'd0:    rd_sel = regs_q[0];
            7'd1:    rd_sel = regs_q[1];
            7'd2:    rd_sel = regs_q[2];
            7'd3:    rd_sel = regs_q[3];
            7'd4:    rd_sel = regs_q[4];
            7'd5:    rd_sel = {31'h0, en_q};
            default: rd_sel = 32'h0;
        endcase
        if (!rx_addr_ok) rd_sel = 32'h0;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cmd_d       = cmd_q;
        hold_d      = hold_q;
        snap_d      = snap_q;
        tmo_d       = tmo_q;
        tx_dv_d     = 1'b0;
        tx_byte_d   = 8'h00;
        frame_err_d = 1'b0;
        regs_d      = regs_q;
        en_d        = en_q;
        commit_en   = 1'b0;
        commit_data = 32'h0;
`ifdef PWM_REGBANK_CHECKSUM_EN
        chk_d       = chk_q;
`endif

        // An rx_dv arriving on the expiry cycle takes priority over the timeout.
        if (state_q == S_IDLE || rx_dv) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            state_d     = S_IDLE;
            tmo_d       = '0;
            frame_err_d = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (rx_dv) begin
            tx_dv_d = 1'b1;
            case (state_q)
                S_IDLE: begin
                    cmd_d   = rx_byte;
                    idx_d   = 2'd0;
                    hold_d  = '0;
                    state_d = S_DATA;
`ifdef PWM_REGBANK_CHECKSUM_EN
                    chk_d   = rx_byte;
`endif
                    if (!rx_byte[7]) begin
                        tx_byte_d   = rd_sel[31:24];
                        snap_d      = {rd_sel[23:0], 8'h00};
                        frame_err_d = !rx_addr_ok;
                    end
                end
                S_DATA: begin
                    hold_d = wr_data[HW-1:0];
                    idx_d  = idx_q + 2'd1;
`ifdef PWM_REGBANK_CHECKSUM_EN
                    chk_d  = chk_q ^ rx_byte;
`endif
                    if (!cmd_q[7] && idx_q != 2'd3) begin
                        tx_byte_d = snap_q[31:24];
                        snap_d    = {snap_q[23:0], 8'h00};
                    end
                    if (idx_q == 2'd3) begin
`ifdef PWM_REGBANK_CHECKSUM_EN
                        state_d = cmd_q[7] ? S_CHK : S_IDLE;
`else
                        state_d = S_IDLE;
                        if (cmd_q[7]) begin
                            commit_en   = cmd_addr_ok;
                            commit_data = wr_data;
                            frame_err_d = !cmd_addr_ok;
                        end
`endif
                    end
                end
`ifdef PWM_REGBANK_CHECKSUM_EN
                S_CHK: begin
                    state_d = S_IDLE;
                    if (chk_q == rx_byte) begin
                        tx_byte_d   = 8'hAC;
                        commit_en   = cmd_addr_ok;
                        commit_data = hold_q;
                        frame_err_d = !cmd_addr_ok;
                    end else begin
                        tx_byte_d   = 8'hEE;
                        frame_err_d = 1'b1;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end

        if (commit_en) begin
            case (cmd_q[6:0])
                7'd0:    regs_d[0] = commit_data;
                7'd1:    regs_d[1] = commit_data;
                7'd2:    regs_d[2] = commit_data;
                7'd3:    regs_d[3] = commit_data;
                7'd4:    regs_d[4] = commit_data;
                7'd5:    en_d      = commit_data[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            cmd_q       <= 8'h00;
            hold_q      <= '0;
            snap_q      <= 32'h0;
            tmo_q       <= '0;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= 8'h00;
            frame_err_q <= 1'b0;
            en_q        <= 1'b0;
            for (int i = 0; i < 5; i++) regs_q[i] <= 32'h0;
`ifdef PWM_REGBANK_CHECKSUM_EN
            chk_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cmd_q       <= cmd_d;
            hold_q      <= hold_d;
            snap_q      <= snap_d;
            tmo_q       <= tmo_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            frame_err_q <= frame_err_d;
            en_q        <= en_d;
            for (int i = 0; i < 5; i++) regs_q[i] <= regs_d[i];
`ifdef PWM_REGBANK_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign tx_dv         = tx_dv_q;
    assign tx_byte       = tx_byte_q;
    assign frame_err     = frame_err_q;
    assign counter_value = regs_q[0];
    assign prescaler     = regs_q[1];
    assign duty_cycle_1  = regs_q[2];
    assign duty_cycle_2  = regs_q[3];
    assign duty_cycle_3  = regs_q[4];
    assign enable_pwm    = en_q;
endmodule

// File: tb/tb_pwm_spi_regbank.sv
// Self-checking bench for pwm_spi_regbank: directed vector table, corner sequences and
// randomized frames checked against a frame-level register model.
module tb_pwm_spi_regbank;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic [31:0] counter_value, prescaler, duty_cycle_1, duty_cycle_2, duty_cycle_3;
    logic        enable_pwm;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_regs [6];

    pwm_spi_regbank #(.TIMEOUT_CYCLES(16), .NUM_REGS(6)) dut (
        .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .tx_dv(tx_dv), .tx_byte(tx_byte),
        .counter_value(counter_value), .prescaler(prescaler),
        .duty_cycle_1(duty_cycle_1), .duty_cycle_2(duty_cycle_2), .duty_cycle_3(duty_cycle_3),
        .enable_pwm(enable_pwm), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  b   [5];
        logic [7:0]  rep [5];
        int          err;
        int          ridx;
        logic [31:0] rval;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_reg(input int i);
        case (i)
            0:       return counter_value;
            1:       return prescaler;
            2:       return duty_cycle_1;
            3:       return duty_cycle_2;
            4:       return duty_cycle_3;
            default: return {31'h0, enable_pwm};
        endcase
    endfunction

    function automatic vec_t mk(input logic [39:0] bytes, input logic [39:0] reps,
                                input int err, input int ridx, input logic [31:0] rval);
        vec_t v;
        for (int j = 0; j < 5; j++) begin
            v.b[j]   = bytes[39-8*j -: 8];
            v.rep[j] = reps[39-8*j -: 8];
        end
        v.err  = err;
        v.ridx = ridx;
        v.rval = rval;
        return v;
    endfunction

    // One byte on the SPI side: pulse rx_dv for a cycle, then sample the reply.
    task automatic send_byte(input logic [7:0] b, output logic [7:0] rep, output logic err);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_byte = 8'($urandom);
        check("tx_dv after rx_dv", {31'h0, tx_dv}, 32'h1);
        rep = tx_byte;
        err = frame_err;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("quiet tx_dv/frame_err", {30'h0, tx_dv, frame_err}, 32'h0);
        end
    endtask

    function automatic logic [7:0] xor5(input logic [7:0] fb [$]);
        return fb[0] ^ fb[1] ^ fb[2] ^ fb[3] ^ fb[4];
    endfunction

    // Frame-level reference: reads return the register value MSB first on bytes 0..3,
    // writes commit after the last byte when address (and checksum) are good.
    task automatic run_frame(input logic [7:0] fb [$], input bit gaps);
        logic [7:0]  rep, exp_rep;
        logic        err;
        logic [6:0]  a;
        logic [31:0] d, val;
        bit          wr, ok, chk_ok, exp_err;
        int          last;
        wr     = fb[0][7];
        a      = fb[0][6:0];
        ok     = (a < 6);
        d      = {fb[1], fb[2], fb[3], fb[4]};
        val    = (ok && !wr) ? model_regs[a] : 32'h0;
        last   = fb.size() - 1;
        chk_ok = 1'b1;
`ifdef PWM_REGBANK_CHECKSUM_EN
        if (wr) chk_ok = (fb[5] == xor5(fb));
`endif
        for (int i = 0; i <= last; i++) begin
            if (gaps && i > 0) idle($urandom_range(0, 3));
            send_byte(fb[i], rep, err);
            if (!wr) exp_rep = (i < 4) ? val[31-8*i -: 8] : 8'h00;
            else     exp_rep = (i == 5) ? (chk_ok ? 8'hAC : 8'hEE) : 8'h00;
            exp_err = wr ? (i == last && (!ok || !chk_ok)) : (i == 0 && !ok);
            check($sformatf("frame %02h byte%0d tx_byte", fb[0], i), {24'h0, rep}, {24'h0, exp_rep});
            check($sformatf("frame %02h byte%0d frame_err", fb[0], i), {31'h0, err}, {31'h0, exp_err});
        end
        if (wr && ok && chk_ok) model_regs[a] = (a == 5) ? {31'h0, d[0]} : d;
        for (int r = 0; r < 6; r++)
            check($sformatf("reg%0d after frame %02h", r, fb[0]), dut_reg(r), model_regs[r]);
    endtask

    task automatic wr_frame(input logic [6:0] a, input logic [31:0] d, input bit gaps);
        logic [7:0] fb [$];
        fb = '{{1'b1, a}, d[31:24], d[23:16], d[15:8], d[7:0]};
`ifdef PWM_REGBANK_CHECKSUM_EN
        fb.push_back(xor5(fb));
`endif
        run_frame(fb, gaps);
    endtask

    task automatic rd_frame(input logic [6:0] a, input bit gaps);
        logic [7:0] fb [$];
        fb = '{{1'b0, a}, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        run_frame(fb, gaps);
    endtask

    initial begin
        vec_t       vecs [8];
        logic [7:0] rep, x;
        logic       err;
        int         nerr, k;
        bit         seen;
        logic [7:0] fb [$];

        vecs[0] = mk(40'h80_00_00_04_E2, 40'h00_00_00_00_00, 0, 0, 32'h0000_04E2);
        vecs[1] = mk(40'h00_00_00_00_00, 40'h00_00_04_E2_00, 0, 0, 32'h0000_04E2);
        vecs[2] = mk(40'h85_FF_FF_FF_FF, 40'h00_00_00_00_00, 0, 5, 32'h0000_0001);
        vecs[3] = mk(40'h87_AA_BB_CC_DD, 40'h00_00_00_00_00, 1, 0, 32'h0000_04E2);
        vecs[4] = mk(40'h07_00_00_00_00, 40'h00_00_00_00_00, 1, 5, 32'h0000_0001);
        vecs[5] = mk(40'h81_12_34_56_78, 40'h00_00_00_00_00, 0, 1, 32'h1234_5678);
        vecs[6] = mk(40'h01_00_00_00_00, 40'h12_34_56_78_00, 0, 1, 32'h1234_5678);
        vecs[7] = mk(40'h05_55_55_55_55, 40'h00_00_00_01_00, 0, 5, 32'h0000_0001);

        rst_n   = 1'b0;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        for (int r = 0; r < 6; r++) check($sformatf("reset reg%0d", r), dut_reg(r), 32'h0);
        check("reset tx_dv", {31'h0, tx_dv}, 32'h0);
        check("reset tx_byte", {24'h0, tx_byte}, 32'h0);
        check("reset frame_err", {31'h0, frame_err}, 32'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            nerr = 0;
            for (int j = 0; j < 5; j++) begin
                send_byte(vecs[v].b[j], rep, err);
                check($sformatf("vec%0d byte%0d tx_byte", v, j), {24'h0, rep}, {24'h0, vecs[v].rep[j]});
                nerr += int'(err);
            end
`ifdef PWM_REGBANK_CHECKSUM_EN
            if (vecs[v].b[0][7]) begin
                x = vecs[v].b[0] ^ vecs[v].b[1] ^ vecs[v].b[2] ^ vecs[v].b[3] ^ vecs[v].b[4];
                send_byte(x, rep, err);
                check($sformatf("vec%0d checksum reply", v), {24'h0, rep}, 32'h0000_00AC);
                nerr += int'(err);
            end
`endif
            @(negedge clk);
            nerr += int'(frame_err);
            check($sformatf("vec%0d frame_err pulses", v), nerr, vecs[v].err);
            check($sformatf("vec%0d reg%0d", v, vecs[v].ridx), dut_reg(vecs[v].ridx), vecs[v].rval);
        end
        model_regs = '{32'h0000_04E2, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h1};

        // Back-to-back write then read of the same register.
        wr_frame(7'd1, 32'hDEAD_BEEF, 1'b0);
        rd_frame(7'd1, 1'b0);

        // Abandoned write: two data bytes then silence.
        wr_frame(7'd2, 32'hCAFE_F00D, 1'b0);
        send_byte(8'h82, rep, err);
        send_byte(8'h11, rep, err);
        send_byte(8'h22, rep, err);
        check("partial write reply", {24'h0, rep}, 32'h0);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (frame_err) seen = 1'b1;
        end
        check("timeout idle cycles until frame_err", k, 16);
        check("duty_cycle_1 after timeout", duty_cycle_1, 32'hCAFE_F00D);
        rd_frame(7'd2, 1'b0);

`ifdef PWM_REGBANK_CHECKSUM_EN
        wr_frame(7'd3, 32'd625, 1'b0);
        check("duty_cycle_2 checksum write", duty_cycle_2, 32'd625);
        fb = '{8'h83, 8'h00, 8'h00, 8'h02, 8'h99, 8'h00};
        run_frame(fb, 1'b0);
`endif

        for (int n = 0; n < 60; n++) begin
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                fb = '{{1'b1, 7'($urandom_range(0, 7))}, 8'($urandom), 8'($urandom),
                       8'($urandom), 8'($urandom)};
`ifdef PWM_REGBANK_CHECKSUM_EN
                x = xor5(fb);
                if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
                fb.push_back(x);
`endif
                run_frame(fb, 1'b1);
            end else begin
                rd_frame(7'($urandom_range(0, 7)), 1'b1);
            end
        end

        // Reset in the middle of a write frame.
        send_byte(8'h81, rep, err);
        send_byte(8'hAA, rep, err);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 6; r++) check($sformatf("mid-frame reset reg%0d", r), dut_reg(r), 32'h0);
        check("mid-frame reset tx_dv", {31'h0, tx_dv}, 32'h0);
        rst_n = 1'b1;
        model_regs = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        wr_frame(7'd4, 32'h0102_0304, 1'b0);
        rd_frame(7'd4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
